vga_fb_ctrl: RTL and testbench
==============================

VGA_FB_CTRL -- requirements
Module: vga_fb_ctrl

Interface
REQ-001 Parameters: FB_W, default 192, frame-buffer columns; FB_H, default 108, frame-buffer rows; SCALE, default 10, screen pixels per buffer pixel in both axes; AW, default 15, buffer address width.
REQ-002 Reset reset_n is asynchronous and active-low; clock is clk.
REQ-003 Port list:
- clk  in  1  pixel clock
- reset_n  in  1  async active-low reset
- sof  in  1  one-cycle pulse, at least 1 cycle before the first pix_req of a frame
- pix_req  in  1  high for each active-video pixel cycle
- vblank  in  1  high during vertical blanking
- cfg_blank_only  in  1  1 = host writes accepted only while vblank=1
- wr_valid  in  1  host write request
- wr_addr  in  AW  host buffer address, row*FB_W+col
- wr_data  in  24  host RGB888 data
- wr_ready  out  1  host write accepted this cycle when wr_valid=1
- mem_addr  out  AW  single-port RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  24  RAM write data
- mem_rdata  in  24  RAM read data, 1-cycle synchronous latency
- pix_rgb  out  24  pixel to display
- pix_valid  out  1  pix_rgb qualifier
- wr_oob  out  1  sticky: out-of-range write was seen
- oob_clr  in  1  clears wr_oob
- frame_cnt  out  8  frame counter

Function
REQ-004 The display read has absolute priority: wr_ready = !pix_req && (!cfg_blank_only || vblank), combinationally.
REQ-005 A host write is accepted when wr_valid && wr_ready; in that cycle mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data.
REQ-006 An accepted write with wr_addr >= FB_W*FB_H does not assert mem_we and sets wr_oob=1 on the next edge.
REQ-007 oob_clr clears wr_oob; when oob_clr and a new out-of-range write occur together, the set wins.
REQ-008 Read addressing uses counters only, no dividers: sx (0..SCALE-1), col (0..FB_W-1), sy (0..SCALE-1), row (0..FB_H-1).
REQ-009 Counter rules: sof clears all counters. Each pix_req increments sx. When sx wraps, col increments. When col wraps, sy increments. When sy wraps, row increments.
REQ-010 FSM states: IDLE (reset), ACTIVE, DONE.
- sof in any state goes to ACTIVE.
- In ACTIVE, the pix_req that wraps row from FB_H-1 goes to DONE.
- DONE holds until the next sof.
REQ-011 In ACTIVE with pix_req=1, mem_addr = row*FB_W+col and mem_we=0. The multiply is realized as an incrementally maintained row-base register.
REQ-012 In IDLE or DONE, pix_req still produces pix_valid but pix_rgb=24'h000000, and no RAM read is required.
REQ-013 Latency: pix_req at cycle N gives pix_valid=1 and pix_rgb at cycle N+2, registered. Back-to-back pix_req gives back-to-back output.
REQ-014 When neither a read nor a write is active, mem_addr holds its last value and mem_we=0.
REQ-015 frame_cnt increments by 1 on each sof and wraps from 255 to 0.
REQ-016 A sof coincident with pix_req: counters clear and that pixel reads address 0.
REQ-017 mem_we is never 1 in a cycle with pix_req=1.

Reset
REQ-018 When reset_n=0, the block immediately enters the following state, regardless of any operation in progress:
- FSM=IDLE; all counters 0
- pix_valid=0, pix_rgb=0
- mem_we=0, mem_addr=0, mem_wdata=0
- wr_oob=0, frame_cnt=0
REQ-019 After reset release, no RAM read occurs until the first sof.

Verification
REQ-020 Write 24'hFF0000 to addr 0 and 24'h00FF00 to addr 1 during vblank, then sof followed by 20 pix_req. Required: pix_valid from cycle 2 after the first pix_req; 10 pixels of FF0000 then 10 of 00FF00.
REQ-021 Hold wr_valid=1 while pix_req=1 for 5 cycles. Required: wr_ready=0 and mem_we=0 for those 5 cycles; the write completes in the first cycle with pix_req=0.
REQ-022 cfg_blank_only=1, vblank=0, pix_req=0, wr_valid=1. Required: wr_ready=0. Raising vblank accepts the write in the same cycle.
REQ-023 Write to addr 20736 (=FB_W*FB_H). Required: mem_we=0, then wr_oob=1. Pulse oob_clr: wr_oob=0.
REQ-024 Run a full frame of 1920*1080 pix_req, then 10 extra pix_req. Required: the last in-frame read is addr 20735; the extras output 24'h000000; the FSM is in DONE.
REQ-025 Assert reset_n=0 mid-line with pix_req active. Required: pix_valid=0 and frame_cnt=0 immediately; after release and sof, the first read is addr 0.

Source files
------------

// File: rtl/vga_fb_ctrl.sv
// Frame-buffer controller: upscales an FB_W x FB_H RGB888 buffer by SCALE for display,
// sharing one single-port RAM between display reads (priority) and host writes.
module vga_fb_ctrl #(
    parameter int FB_W  = 192,
    parameter int FB_H  = 108,
    parameter int SCALE = 10,
    parameter int AW    = 15
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          sof,
    input  logic          pix_req,
    input  logic          vblank,
    input  logic          cfg_blank_only,
    input  logic          wr_valid,
    input  logic [AW-1:0] wr_addr,
    input  logic [23:0]   wr_data,
    output logic          wr_ready,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [23:0]   mem_wdata,
    input  logic [23:0]   mem_rdata,
    output logic [23:0]   pix_rgb,
    output logic          pix_valid,
    output logic          wr_oob,
    input  logic          oob_clr,
    output logic [7:0]    frame_cnt
);

    localparam int SXW     = $clog2(SCALE + 1);
    localparam int CW      = $clog2(FB_W + 1);
    localparam int RW      = $clog2(FB_H + 1);
    localparam int FB_SIZE = FB_W * FB_H;

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t state, state_nxt;

    logic [SXW-1:0] sx, sy, sx_b, sy_b, sx_nxt, sy_nxt;
    logic [CW-1:0]  col, col_b, col_nxt;
    logic [RW-1:0]  row, row_b, row_nxt;
    logic [AW-1:0]  row_base, base_b, base_nxt;
    logic [AW-1:0]  rd_addr, addr_q;
    logic [23:0]    wdata_q;
    logic           rd_en, frame_end, wr_acc, wr_oob_hit;
    logic           req_q, rd_q;

    // A sof in the same cycle as pix_req makes that pixel the first of the frame.
    always_comb begin
        sx_b   = sof ? '0 : sx;
        col_b  = sof ? '0 : col;
        sy_b   = sof ? '0 : sy;
        row_b  = sof ? '0 : row;
        base_b = sof ? '0 : row_base;

        rd_en   = reset_n && pix_req && (sof || state == ACTIVE);
        rd_addr = base_b + AW'(col_b);

        sx_nxt    = sx_b;
        col_nxt   = col_b;
        sy_nxt    = sy_b;
        row_nxt   = row_b;
        base_nxt  = base_b;
        frame_end = 1'b0;

        if (rd_en) begin
            if (sx_b != SXW'(SCALE - 1)) begin
                sx_nxt = sx_b + 1'b1;
            end else begin
                sx_nxt = '0;
                if (col_b != CW'(FB_W - 1)) begin
                    col_nxt = col_b + 1'b1;
                end else begin
                    col_nxt = '0;
                    if (sy_b != SXW'(SCALE - 1)) begin
                        sy_nxt = sy_b + 1'b1;
                    end else begin
                        sy_nxt = '0;
                        if (row_b != RW'(FB_H - 1)) begin
                            row_nxt  = row_b + 1'b1;
                            base_nxt = base_b + AW'(FB_W);
                        end else begin
                            row_nxt   = '0;
                            base_nxt  = '0;
                            frame_end = 1'b1;
                        end
                    end
                end
            end
        end

        state_nxt = state;
        if (frame_end) begin
            state_nxt = DONE;
        end else if (sof) begin
            state_nxt = ACTIVE;
        end
    end

    // Host port only sees the RAM when the display is not reading it.
    always_comb begin
        wr_ready   = !pix_req && (!cfg_blank_only || vblank);
        wr_acc     = reset_n && wr_valid && wr_ready;
        wr_oob_hit = wr_acc && (32'(wr_addr) >= 32'(FB_SIZE));
        mem_we     = wr_acc && !wr_oob_hit;
        mem_wdata  = mem_we ? wr_data : wdata_q;
        if (rd_en) begin
            mem_addr = rd_addr;
        end else if (mem_we) begin
            mem_addr = wr_addr;
        end else begin
            mem_addr = addr_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            sx       <= '0;
            col      <= '0;
            sy       <= '0;
            row      <= '0;
            row_base <= '0;
        end else begin
            state    <= state_nxt;
            sx       <= sx_nxt;
            col      <= col_nxt;
            sy       <= sy_nxt;
            row      <= row_nxt;
            row_base <= base_nxt;
        end
    end

    // Two-stage pixel pipeline matching the RAM's one-cycle read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            req_q     <= 1'b0;
            rd_q      <= 1'b0;
            pix_valid <= 1'b0;
            pix_rgb   <= '0;
            wr_oob    <= 1'b0;
            frame_cnt <= '0;
        end else begin
            addr_q    <= mem_addr;
            wdata_q   <= mem_wdata;
            req_q     <= pix_req;
            rd_q      <= rd_en;
            pix_valid <= req_q;
            pix_rgb   <= rd_q ? mem_rdata : 24'h000000;
            if (wr_oob_hit) begin
                wr_oob <= 1'b1;
            end else if (oob_clr) begin
                wr_oob <= 1'b0;
            end
            if (sof) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_ctrl.sv
// Directed bench for vga_fb_ctrl, run on a reduced 16x8 buffer so a whole frame stays short;
// a behavioural single-port RAM returns an address-derived pattern for never-written words.
module tb_vga_fb_ctrl;

    localparam int FB_W    = 16;
    localparam int FB_H    = 8;
    localparam int SCALE   = 10;
    localparam int AW      = 15;
    localparam int FB_SIZE = FB_W * FB_H;
    localparam int LINE    = FB_W * SCALE;
    localparam int TOTAL   = LINE * FB_H * SCALE;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          sof, pix_req, vblank, cfg_blank_only, wr_valid, oob_clr;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_data;
    logic          wr_ready, mem_we, pix_valid, wr_oob;
    logic [AW-1:0] mem_addr;
    logic [23:0]   mem_wdata, mem_rdata, pix_rgb;
    logic [7:0]    frame_cnt;

    logic [23:0] ram [0:(1<<AW)-1];
    bit          written [0:(1<<AW)-1];
    logic [23:0] exp_mem [0:FB_SIZE-1];
    int          tests_run = 0;
    int          tests_failed = 0;
    int          exp_fc = 0;

    vga_fb_ctrl #(.FB_W(FB_W), .FB_H(FB_H), .SCALE(SCALE), .AW(AW)) dut (
        .clk(clk), .reset_n(reset_n), .sof(sof), .pix_req(pix_req), .vblank(vblank),
        .cfg_blank_only(cfg_blank_only), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ready(wr_ready), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .pix_rgb(pix_rgb),
        .pix_valid(pix_valid), .wr_oob(wr_oob), .oob_clr(oob_clr), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] pattern(input logic [AW-1:0] a);
        return {4'hA, 5'h00, a};
    endfunction

    function automatic int addr_of(input int idx);
        int x, y;
        x = idx % LINE;
        y = idx / LINE;
        return (y / SCALE) * FB_W + x / SCALE;
    endfunction

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
        mem_rdata <= written[mem_addr] ? ram[mem_addr] : pattern(mem_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        sof = 0; pix_req = 0; vblank = 0; cfg_blank_only = 0;
        wr_valid = 0; wr_addr = '0; wr_data = '0; oob_clr = 0;
        #1 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({pix_valid, mem_we, wr_oob} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got valid/we/oob=%b required 000", {pix_valid, mem_we, wr_oob});
        end
        tests_run++;
        if (pix_rgb !== 24'h0 || mem_wdata !== 24'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data: got rgb=%h wdata=%h required 0", pix_rgb, mem_wdata);
        end
        tests_run++;
        if (mem_addr !== '0 || frame_cnt !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_addr_cnt: got addr=%0d fc=%0d required 0", mem_addr, frame_cnt);
        end
        tick(); tick();
        reset_n = 1'b1;
        tick();
        pix_req = 1;
        tick(); tick();
        tests_run++;
        if (pix_valid !== 1'b1 || pix_rgb !== 24'h0 || mem_addr !== '0) begin
            tests_failed++;
            $display("[TB] FAIL idle_pixel: got valid=%b rgb=%h addr=%0d required 1/000000/0", pix_valid, pix_rgb, mem_addr);
        end
        pix_req = 0;
        tick(); tick(); tick();
    endtask

    task automatic test_basic_frame();
        logic [23:0] exp_px;
        vblank = 1; cfg_blank_only = 1; wr_valid = 1; wr_addr = 0; wr_data = 24'hFF0000;
        #1;
        tests_run++;
        if ({wr_ready, mem_we} !== 2'b11 || mem_addr !== 0 || mem_wdata !== 24'hFF0000) begin
            tests_failed++;
            $display("[TB] FAIL write0: got rdy/we=%b addr=%0d data=%h required 11/0/ff0000", {wr_ready, mem_we}, mem_addr, mem_wdata);
        end
        tick();
        wr_addr = 1; wr_data = 24'h00FF00;
        #1;
        tests_run++;
        if (mem_we !== 1'b1 || mem_addr !== 1 || mem_wdata !== 24'h00FF00) begin
            tests_failed++;
            $display("[TB] FAIL write1: got we=%b addr=%0d data=%h required 1/1/00ff00", mem_we, mem_addr, mem_wdata);
        end
        tick();
        exp_mem[0] = 24'hFF0000;
        exp_mem[1] = 24'h00FF00;
        wr_valid = 0; vblank = 0; cfg_blank_only = 0;
        sof = 1;
        tick();
        sof = 0;
        exp_fc++;
        tests_run++;
        if (frame_cnt !== 8'(exp_fc)) begin
            tests_failed++;
            $display("[TB] FAIL frame_cnt_first: got %0d required %0d", frame_cnt, exp_fc);
        end
        for (int i = 0; i < 22; i++) begin
            pix_req = (i < 20);
            #1;
            if (i == 10) begin
                tests_run++;
                if (mem_addr !== 1) begin
                    tests_failed++;
                    $display("[TB] FAIL col_step_addr: got %0d required 1", mem_addr);
                end
            end
            exp_px = (i - 2 < 10) ? 24'hFF0000 : 24'h00FF00;
            tests_run++;
            if (i < 2 && pix_valid !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL basic_latency[%0d]: got valid=%b required 0", i, pix_valid);
            end else if (i >= 2 && (pix_valid !== 1'b1 || pix_rgb !== exp_px)) begin
                tests_failed++;
                $display("[TB] FAIL basic_pixel[%0d]: got valid=%b rgb=%h required 1/%h", i - 2, pix_valid, pix_rgb, exp_px);
            end
            tick();
        end
        pix_req = 0;
        tick();
    endtask

    task automatic test_write_blocked();
        vblank = 1; wr_valid = 1; wr_addr = 5; wr_data = 24'h123456; pix_req = 1;
        for (int k = 0; k < 5; k++) begin
            #1;
            tests_run++;
            if ({wr_ready, mem_we} !== 2'b00) begin
                tests_failed++;
                $display("[TB] FAIL blocked_write[%0d]: got rdy/we=%b required 00", k, {wr_ready, mem_we});
            end
            tick();
        end
        pix_req = 0;
        #1;
        tests_run++;
        if ({wr_ready, mem_we} !== 2'b11 || mem_addr !== 5 || mem_wdata !== 24'h123456) begin
            tests_failed++;
            $display("[TB] FAIL unblocked_write: got rdy/we=%b addr=%0d data=%h required 11/5/123456", {wr_ready, mem_we}, mem_addr, mem_wdata);
        end
        tick();
        exp_mem[5] = 24'h123456;
        wr_valid = 0;
        tick(); tick();
    endtask

    task automatic test_blank_only();
        cfg_blank_only = 1; vblank = 0; wr_valid = 1; wr_addr = 6; wr_data = 24'hABCDEF;
        #1;
        tests_run++;
        if ({wr_ready, mem_we} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL blank_only_hold: got rdy/we=%b required 00", {wr_ready, mem_we});
        end
        vblank = 1;
        #1;
        tests_run++;
        if ({wr_ready, mem_we} !== 2'b11 || mem_addr !== 6) begin
            tests_failed++;
            $display("[TB] FAIL blank_only_accept: got rdy/we=%b addr=%0d required 11/6", {wr_ready, mem_we}, mem_addr);
        end
        tick();
        exp_mem[6] = 24'hABCDEF;
        wr_valid = 0;
        #1;
        tests_run++;
        if (mem_we !== 1'b0 || mem_addr !== 6) begin
            tests_failed++;
            $display("[TB] FAIL addr_hold: got we=%b addr=%0d required 0/6", mem_we, mem_addr);
        end
        tick();
    endtask

    task automatic test_oob();
        cfg_blank_only = 0; wr_valid = 1; wr_addr = AW'(FB_SIZE - 1); wr_data = 24'h0BEEF0;
        #1;
        tests_run++;
        if (mem_we !== 1'b1 || mem_addr !== AW'(FB_SIZE - 1)) begin
            tests_failed++;
            $display("[TB] FAIL last_addr_write: got we=%b addr=%0d required 1/%0d", mem_we, mem_addr, FB_SIZE - 1);
        end
        tick();
        exp_mem[FB_SIZE-1] = 24'h0BEEF0;
        wr_addr = AW'(FB_SIZE); wr_data = 24'h777777;
        #1;
        tests_run++;
        if (wr_ready !== 1'b1 || mem_we !== 1'b0 || wr_oob !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL oob_write: got rdy=%b we=%b oob=%b required 1/0/0", wr_ready, mem_we, wr_oob);
        end
        tick();
        wr_valid = 0;
        tests_run++;
        if (wr_oob !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL oob_set: got %b required 1", wr_oob);
        end
        oob_clr = 1;
        tick();
        oob_clr = 0;
        tests_run++;
        if (wr_oob !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL oob_clear: got %b required 0", wr_oob);
        end
        wr_valid = 1; wr_addr = AW'(FB_SIZE + 3); oob_clr = 1;
        tick();
        wr_valid = 0; oob_clr = 0;
        tests_run++;
        if (wr_oob !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL oob_set_beats_clr: got %b required 1", wr_oob);
        end
        oob_clr = 1;
        tick();
        oob_clr = 0;
        vblank = 0;
        tick();
    endtask

    task automatic test_full_frame();
        int addr_errs, px_errs, extra_errs, hold_errs, j;
        logic [23:0] exp_px;
        addr_errs = 0; px_errs = 0; extra_errs = 0; hold_errs = 0;
        sof = 1;
        tick();
        sof = 0;
        exp_fc++;
        for (int i = 0; i < TOTAL + 12; i++) begin
            pix_req = (i < TOTAL + 10);
            #1;
            if (i < TOTAL && mem_addr !== AW'(addr_of(i))) begin
                if (addr_errs == 0) $display("[TB] FAIL frame_addr[%0d]: got %0d required %0d", i, mem_addr, addr_of(i));
                addr_errs++;
            end
            if (i == TOTAL - 1) begin
                tests_run++;
                if (mem_addr !== AW'(FB_SIZE - 1)) begin
                    tests_failed++;
                    $display("[TB] FAIL last_read_addr: got %0d required %0d", mem_addr, FB_SIZE - 1);
                end
            end
            if (i >= TOTAL && i < TOTAL + 10 && mem_addr !== AW'(FB_SIZE - 1)) hold_errs++;
            if (i >= 2) begin
                j = i - 2;
                exp_px = (j < TOTAL) ? exp_mem[addr_of(j)] : 24'h000000;
                if (pix_valid !== 1'b1 || pix_rgb !== exp_px) begin
                    if (j < TOTAL) px_errs++;
                    else extra_errs++;
                end
            end
            tick();
        end
        pix_req = 0;
        tests_run++;
        if (addr_errs != 0) begin
            tests_failed++;
            $display("[TB] FAIL frame_addrs: got %0d bad addresses required 0", addr_errs);
        end
        tests_run++;
        if (px_errs != 0) begin
            tests_failed++;
            $display("[TB] FAIL frame_pixels: got %0d bad pixels required 0", px_errs);
        end
        tests_run++;
        if (extra_errs != 0) begin
            tests_failed++;
            $display("[TB] FAIL done_pixels: got %0d non-black extras required 0", extra_errs);
        end
        tests_run++;
        if (hold_errs != 0) begin
            tests_failed++;
            $display("[TB] FAIL done_addr_hold: got %0d moved addresses required 0", hold_errs);
        end
        tick();
    endtask

    task automatic test_sof_with_pix();
        sof = 1; pix_req = 1;
        #1;
        tests_run++;
        if (mem_addr !== 0 || mem_we !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL sof_pix_addr: got addr=%0d we=%b required 0/0", mem_addr, mem_we);
        end
        exp_fc++;
        tick();
        sof = 0;
        for (int i = 1; i <= 10; i++) begin
            #1;
            if (i == 2) begin
                tests_run++;
                if (pix_valid !== 1'b1 || pix_rgb !== exp_mem[0]) begin
                    tests_failed++;
                    $display("[TB] FAIL sof_pix_data: got valid=%b rgb=%h required 1/%h", pix_valid, pix_rgb, exp_mem[0]);
                end
            end
            if (i == 10) begin
                tests_run++;
                if (mem_addr !== 1) begin
                    tests_failed++;
                    $display("[TB] FAIL sof_pix_col: got %0d required 1", mem_addr);
                end
            end
            tick();
        end
        pix_req = 0;
        tick(); tick();
    endtask

    task automatic test_frame_cnt_wrap();
        sof = 1;
        repeat (255 - exp_fc) tick();
        sof = 0;
        tests_run++;
        if (frame_cnt !== 8'd255) begin
            tests_failed++;
            $display("[TB] FAIL frame_cnt_max: got %0d required 255", frame_cnt);
        end
        sof = 1;
        tick();
        sof = 0;
        exp_fc = 0;
        tests_run++;
        if (frame_cnt !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL frame_cnt_wrap: got %0d required 0", frame_cnt);
        end
        tick();
    endtask

    task automatic test_reset_midline();
        sof = 1;
        tick();
        sof = 0; pix_req = 1;
        repeat (15) tick();
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (pix_valid !== 1'b0 || frame_cnt !== 8'd0 || mem_addr !== 0 || mem_we !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midline_reset: got valid=%b fc=%0d addr=%0d we=%b required 0/0/0/0", pix_valid, frame_cnt, mem_addr, mem_we);
        end
        tick();
        reset_n = 1'b1; pix_req = 0;
        tick();
        sof = 1; pix_req = 1;
        #1;
        tests_run++;
        if (mem_addr !== 0) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_addr: got %0d required 0", mem_addr);
        end
        tick();
        sof = 0; pix_req = 0;
        tick();
        tests_run++;
        if (pix_valid !== 1'b1 || pix_rgb !== exp_mem[0] || frame_cnt !== 8'd1) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_pixel: got valid=%b rgb=%h fc=%0d required 1/%h/1", pix_valid, pix_rgb, frame_cnt, exp_mem[0]);
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < FB_SIZE; i++) exp_mem[i] = pattern(AW'(i));
        test_reset();
        test_basic_frame();
        test_write_blocked();
        test_blank_only();
        test_oob();
        test_full_frame();
        test_sof_with_pix();
        test_frame_cnt_wrap();
        test_reset_midline();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
